// File: rtl/adrv9001_rx_burst_ctrl.sv
// Receive burst sequencer for one ADRV9001 channel, clocked by dclk_div.
// Schedules a train of timed bursts: drives rx_enable, counts rx_valid
// samples, closes each burst after burst_len samples, waits out the period.
//
// Ports:
//   clk          sample clock (receive channel m_axis_aclk)
//   rstn         synchronous active-low reset
//   start        pulse, begins a burst train (config latched here)
//   abort        pulse, ends the train; wins over a same-cycle start
//   burst_len    samples per burst
//   burst_period cycles from one enable rise to the next
//   burst_count  bursts per train, 0 = until abort
//   timeout      max cycles from enable rise to first sample, 0 = off
//   rx_valid     receive channel m_axis_tvalid
//   rx_enable    receive channel enable
//   busy         train active
//   done         one-cycle pulse at train end
//   sample_cnt   samples counted in the current burst
//   burst_idx    bursts completed in the current train
//   err_timeout  sticky, no first sample within timeout
//   err_overrun  sticky, burst still running at period expiry
//   err_cfg      one-cycle pulse, start rejected
module adrv9001_rx_burst_ctrl #(
    parameter int CNT_WIDTH = 32,
    parameter int REP_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] burst_len,
    input  logic [CNT_WIDTH-1:0] burst_period,
    input  logic [REP_WIDTH-1:0] burst_count,
    input  logic [CNT_WIDTH-1:0] timeout,
    input  logic                 rx_valid,
    output logic                 rx_enable,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] sample_cnt,
    output logic [REP_WIDTH-1:0] burst_idx,
    output logic                 err_timeout,
    output logic                 err_overrun,
    output logic                 err_cfg
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_GAP,
        S_FINISH
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [REP_WIDTH-1:0] REP_ONE = REP_WIDTH'(1);
    localparam logic [REP_WIDTH-1:0] REP_MAX = '1;

    state_t               state;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] per_q;
    logic [REP_WIDTH-1:0] rep_q;
    logic [CNT_WIDTH-1:0] to_q;
    logic [CNT_WIDTH-1:0] per_cnt;
    logic [CNT_WIDTH-1:0] to_cnt;

    logic cfg_ok;
    logic last_sample;

    assign cfg_ok = (burst_len != '0) && (burst_period != '0)
                 && (burst_period >= burst_len);

    // sample_cnt is 0 in ARM, so this also covers a one-sample burst
    assign last_sample = (sample_cnt == len_q - CNT_ONE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_IDLE;
            len_q       <= '0;
            per_q       <= '0;
            rep_q       <= '0;
            to_q        <= '0;
            per_cnt     <= '0;
            to_cnt      <= '0;
            rx_enable   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sample_cnt  <= '0;
            burst_idx   <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            err_cfg     <= 1'b0;
        end else begin
            done    <= 1'b0;
            err_cfg <= 1'b0;

            // free-running period counter, reloaded on every ARM entry
            if (per_cnt != '0) begin
                per_cnt <= per_cnt - CNT_ONE;
            end

            if ((state == S_ARM || state == S_CAPTURE) && per_cnt == '0) begin
                err_overrun <= 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (cfg_ok) begin
                            len_q       <= burst_len;
                            per_q       <= burst_period;
                            rep_q       <= burst_count;
                            to_q        <= timeout;
                            per_cnt     <= burst_period - CNT_ONE;
                            to_cnt      <= timeout;
                            sample_cnt  <= '0;
                            burst_idx   <= '0;
                            err_timeout <= 1'b0;
                            err_overrun <= 1'b0;
                            busy        <= 1'b1;
                            rx_enable   <= 1'b1;
                            state       <= S_ARM;
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end

                S_ARM, S_CAPTURE: begin
                    if (abort) begin
                        rx_enable <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_FINISH;
                    end else if (rx_valid) begin
                        sample_cnt <= sample_cnt + CNT_ONE;
                        if (last_sample) begin
                            rx_enable <= 1'b0;
                            if (burst_idx != REP_MAX) begin
                                burst_idx <= burst_idx + REP_ONE;
                            end
                            state <= S_GAP;
                        end else begin
                            state <= S_CAPTURE;
                        end
                    end else if (state == S_ARM && to_q != '0) begin
                        if (to_cnt == CNT_ONE) begin
                            err_timeout <= 1'b1;
                            rx_enable   <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= S_FINISH;
                        end else begin
                            to_cnt <= to_cnt - CNT_ONE;
                        end
                    end
                end

                S_GAP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end else if (per_cnt == '0) begin
                        if (rep_q != '0 && burst_idx == rep_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            per_cnt    <= per_q - CNT_ONE;
                            to_cnt     <= to_q;
                            sample_cnt <= '0;
                            rx_enable  <= 1'b1;
                            state      <= S_ARM;
                        end
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
